// File: rtl/alu_seq.sv
// Multi-cycle ALU. ADD/SUB finish in one cycle. Shifts move one bit per cycle.
// MUL is a shift-add loop over WIDTH cycles. A start/busy/done handshake frames each operation.
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] rsdata,
  input  logic [WIDTH-1:0] rmdata,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_aluout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_z, r_n, r_c, r_v;

  logic               w_accept, w_b_is_rm, w_is_sub, w_last, w_add_v;
  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]   w_b_sel, w_addend, w_shift_res, w_acc_next;
  logic [WIDTH:0]     w_sum;
  logic               w_shift_out;
  logic               w_res_we, w_res_c, w_res_v;
  logic [WIDTH-1:0]   w_res;

  // R forms and MUL take rmdata. Everything else takes N.
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_k        = N[SHAMT_W-1:0];
  assign w_b_is_rm  = (!opcode[2] && !opcode[0]) || (opcode == OP_MUL);
  assign w_b_sel    = w_b_is_rm ? rmdata : N;
  assign w_is_sub   = (opcode[2:1] == 2'b01);
  assign w_addend   = w_is_sub ? ~w_b_sel : w_b_sel;
  assign w_sum      = {1'b0, rsdata} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_add_v    = (rsdata[WIDTH-1] == w_addend[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != rsdata[WIDTH-1]);
  assign w_last     = (r_cnt == CNT_ONE);
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_shift_res = {r_a[WIDTH-2:0], 1'b0};
    w_shift_out = r_a[WIDTH-1];
    if (r_op == OP_LSR) begin
      w_shift_res = {1'b0, r_a[WIDTH-1:1]};
      w_shift_out = r_a[0];
    end else if (r_op == OP_ASR) begin
      w_shift_res = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      w_shift_out = r_a[0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE: if (start) begin
        if (!opcode[2])            w_state_next = S_DONE;
        else if (opcode == OP_MUL) w_state_next = S_MUL;
        else if (w_k == '0)        w_state_next = S_DONE;
        else                       w_state_next = S_SHIFT;
      end
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_MUL:   if (w_last) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The result and flags are written only on the edge that enters DONE.
  always_comb begin
    w_res_we = 1'b0;
    w_res    = '0;
    w_res_c  = 1'b0;
    w_res_v  = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        if (!opcode[2]) begin
          w_res_we = 1'b1;
          w_res    = w_sum[WIDTH-1:0];
          w_res_c  = w_sum[WIDTH];
          w_res_v  = w_add_v;
        end else if ((opcode != OP_MUL) && (w_k == '0)) begin
          w_res_we = 1'b1;
          w_res    = rsdata;
        end
      end
      S_SHIFT: if (w_last) begin
        w_res_we = 1'b1;
        w_res    = w_shift_res;
        w_res_c  = w_shift_out;
      end
      S_MUL: if (w_last) begin
        w_res_we = 1'b1;
        w_res    = w_acc_next;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: all datapath registers are plain flops, so each one is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_aluout <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= opcode;
        r_a   <= rsdata;
        r_b   <= w_b_sel;
        r_acc <= '0;
        r_cnt <= (opcode == OP_MUL) ? CNT_FULL : CNT_W'(w_k);
      end else if (r_state == S_SHIFT) begin
        r_a   <= w_shift_res;
        r_cnt <= r_cnt - CNT_ONE;
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_next;
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_res_we) begin
        r_aluout <= w_res;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
        r_c      <= w_res_c;
        r_v      <= w_res_v;
      end
    end
  end

  assign aluout = r_aluout;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq. It checks a 16-bit instance across all operations and an
// 8-bit instance for a shift whose amount field must ignore the upper bits of N.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] rs16 = '0, rm16 = '0, n16 = '0;
  logic        busy16, done16, z16, nf16, c16, v16;
  logic [15:0] out16;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  rs8 = '0, rm8 = '0, n8 = '0;
  logic        busy8, done8, z8, nf8, c8, v8;
  logic [7:0]  out8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .opcode(op16),
    .rsdata(rs16), .rmdata(rm16), .N(n16),
    .busy(busy16), .done(done16), .aluout(out16),
    .flag_z(z16), .flag_n(nf16), .flag_c(c16), .flag_v(v16)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .opcode(op8),
    .rsdata(rs8), .rmdata(rm8), .N(n8),
    .busy(busy8), .done(done8), .aluout(out8),
    .flag_z(z8), .flag_n(nf8), .flag_c(c8), .flag_v(v8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for IDLE, issues one op, and returns cycles from the accept edge to done.
  // When perturb is set, it scrambles the inputs and pulses start while the op is busy.
  task automatic do_op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] m,
                         input logic [15:0] n, input bit perturb, output int lat);
    int guard = 0;
    while (busy16 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    op16 = op; rs16 = a; rm16 = m; n16 = n; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 100) begin
      if (perturb) begin
        rs16 = 16'($urandom); rm16 = 16'($urandom); n16 = 16'($urandom);
        op16 = 3'($urandom); start16 = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start16 = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;

    #12;
    check("rst_busy",  busy16, 0);
    check("rst_done",  done16, 0);
    check("rst_out",   out16, 0);
    check("rst_flags", {z16, nf16, c16, v16}, 4'b0000);
    check("rst_busy8", busy8, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op16(3'b001, 16'h7FFF, 16'h1234, 16'h0001, 0, lat);
    check("addi_lat",   lat, 1);
    check("addi_out",   out16, 16'h8000);
    check("addi_flags", {z16, nf16, c16, v16}, 4'b0101);

    do_op16(3'b010, 16'd5, 16'd5, 16'h00FF, 0, lat);
    check("subr_lat",   lat, 1);
    check("subr_out",   out16, 16'h0000);
    check("subr_flags", {z16, nf16, c16, v16}, 4'b1010);

    // Issued from the DONE cycle of the previous op, so it is accepted on the first IDLE edge.
    do_op16(3'b010, 16'd0, 16'd1, 16'h0000, 0, lat);
    check("subr2_lat",   lat, 1);
    check("subr2_out",   out16, 16'hFFFF);
    check("subr2_flags", {z16, nf16, c16, v16}, 4'b0100);

    do_op16(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 0, lat);
    check("addr_out",   out16, 16'h0000);
    check("addr_flags", {z16, nf16, c16, v16}, 4'b1010);

    do_op16(3'b111, 16'h8001, 16'h0000, 16'd3, 0, lat);
    check("asr_lat",   lat, 4);
    check("asr_out",   out16, 16'hF000);
    check("asr_flags", {z16, nf16, c16, v16}, 4'b0100);

    do_op16(3'b100, 16'h8001, 16'hFFFF, 16'd0, 0, lat);
    check("lsl0_lat",   lat, 1);
    check("lsl0_out",   out16, 16'h8001);
    check("lsl0_flags", {z16, nf16, c16, v16}, 4'b0100);

    do_op16(3'b100, 16'h8001, 16'h0000, 16'd1, 0, lat);
    check("lsl1_lat",   lat, 2);
    check("lsl1_out",   out16, 16'h0002);
    check("lsl1_flags", {z16, nf16, c16, v16}, 4'b0010);

    do_op16(3'b110, 16'h0003, 16'h0000, 16'd1, 0, lat);
    check("lsr1_out",   out16, 16'h0001);
    check("lsr1_flags", {z16, nf16, c16, v16}, 4'b0010);

    do_op16(3'b101, 16'd300, 16'd300, 16'h0007, 1, lat);
    check("mul_lat",   lat, 17);
    check("mul_out",   out16, 16'h5F90);
    check("mul_flags", {z16, nf16, c16, v16}, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mul_idle_after", busy16, 0);
    check("mul_hold",       out16, 16'h5F90);

    do_op16(3'b101, 16'hFFFF, 16'hFFFF, 16'h0000, 0, lat);
    check("mul2_out", out16, 16'h0001);

    do_op16(3'b101, 16'h1234, 16'h0000, 16'hFFFF, 0, lat);
    check("mul0_out",   out16, 16'h0000);
    check("mul0_flags", {z16, nf16, c16, v16}, 4'b1000);

    do_op16(3'b011, 16'h8000, 16'h5555, 16'h0001, 0, lat);
    check("subi_out",   out16, 16'h7FFF);
    check("subi_flags", {z16, nf16, c16, v16}, 4'b0011);

    // Abort a MUL mid-count with an asynchronous reset.
    @(posedge clk); #1;
    op16 = 3'b101; rs16 = 16'd7; rm16 = 16'd9; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("mid_busy", busy16, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  busy16, 0);
    check("arst_done",  done16, 0);
    check("arst_out",   out16, 0);
    check("arst_flags", {z16, nf16, c16, v16}, 4'b0000);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done16) seen = 1'b1;
    end
    check("arst_no_done", seen, 0);

    // Only the low 3 bits of N (3'b010) give the shift amount at WIDTH=8.
    op8 = 3'b110; rs8 = 8'hB4; rm8 = 8'h55; n8 = 8'hF2; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lsr_lat",   lat, 3);
    check("w8_lsr_out",   out8, 8'h2D);
    check("w8_lsr_flags", {z8, nf8, c8, v8}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational datapath ALU.
- Keeps the existing 3-bit opcode map for ADD/SUB (R and I forms). Replaces the fixed 1-bit LSL/LSR with iterative variable-amount shifts, and adds ASR and an iterative MUL.
- Exposes a start/busy/done handshake and registered status flags. The CPU control FSM stalls on busy.

Parameters:
- WIDTH, 16, datapath width in bits (≥4).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only in IDLE.
- opcode  input  3  {instr_bit_15, instr_bit_12_11}.
- rsdata  input  WIDTH  operand A.
- rmdata  input  WIDTH  register operand B.
- N  input  WIDTH  immediate operand / shift amount source.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  single-cycle pulse; result valid.
- aluout  output  WIDTH  registered result; holds until the next done.
- flag_z, flag_n, flag_c, flag_v  output  1 each  registered status; update only with done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy=0, done=0, aluout=0, all flags=0, internal operand/counter registers=0. Reset mid-operation aborts the operation; no done is produced.
- Accept: on the rising edge with state=IDLE and start=1, latch opcode, A=rsdata, and B (rmdata for R forms, N otherwise). Also latch k=N[SHAMT_W-1:0]. Later input changes are ignored until the next accept. start while busy=1 is ignored (not queued).
- Opcode map:
  - 000 ADD R (A+rmdata)
  - 001 ADD I (A+N)
  - 010 SUB R (A−rmdata)
  - 011 SUB I (A−N)
  - 100 LSL by k
  - 101 MUL (low WIDTH bits of A×rmdata)
  - 110 LSR by k
  - 111 ASR by k
- SUB is computed as A + ~B + 1. Arithmetic is modulo 2^WIDTH.
- States: IDLE, SHIFT, MUL, DONE.
  - IDLE→DONE for ADD/SUB (result computed at the accept edge), and for shifts with k=0 (result=A).
  - IDLE→SHIFT for shifts with k>0. One bit position per cycle, with a counter loaded with k. SHIFT→DONE after k cycles.
  - IDLE→MUL for MUL. Shift-add, one multiplier bit per cycle, exactly WIDTH cycles; MUL→DONE.
  - DONE→IDLE unconditionally after one cycle.
- done=1 exactly during the DONE cycle. aluout and flags are written on the edge entering DONE.
- Latency from the accept edge to done high:
  - ADD/SUB: 1 cycle.
  - Shifts: k+1 cycles (1 when k=0).
  - MUL: WIDTH+1 cycles.
- Back-to-back: start is accepted again on the first IDLE cycle after DONE. Minimum issue interval is 2 cycles.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C by operation:
    - ADD: carry-out.
    - SUB: carry-out of A+~B+1 (1 = no borrow).
    - LSL: last bit shifted out of the MSB.
    - LSR/ASR: last bit shifted out of the LSB.
    - Any shift with k=0: 0.
    - MUL: 0.
  - V: signed overflow for ADD/SUB, 0 otherwise.
- Shift fill: LSL and LSR fill with 0; ASR replicates the MSB. k is in [0, WIDTH-1]; upper bits of N are ignored.

Test Plan:
- Reset: assert rst_n=0 during a MUL (mid-count) → busy=0, done=0, aluout=0, flags=0 immediately (async); no later done.
- ADD I with WIDTH=16, rsdata=16'h7FFF, N=1 → done 1 cycle after accept, aluout=16'h8000, Z=0, N=1, C=0, V=1.
- SUB R with rsdata=5, rmdata=5 → aluout=0, Z=1, C=1, V=0. Then immediately (first IDLE) SUB R with rsdata=0, rmdata=1 → aluout=16'hFFFF, C=0, N=1.
- Shifts:
  - ASR with rsdata=16'h8001, N=3 → done at cycle 4, aluout=16'hF000, C=0.
  - LSL with rsdata=16'h8001, N=0 → done at cycle 1, aluout=16'h8001, C=0.
- MUL with rsdata=300, rmdata=300 → done at cycle 17, aluout=16'h5F90 (90000 mod 65536=24464), C=0, V=0. Operand changes and start pulses while busy are ignored.
- Parameter sweep at WIDTH=8: LSR with rsdata=8'hB4, N=8'hF2 (k=2, upper bits ignored) → aluout=8'h2D, C=0, done at cycle 3.
